hilo_mdu: RTL and testbench

Parametrised HI/LO special-register unit for the MIPS pipeline: architectural HI/LO storage, an N-source priority forwarding network, and a stall-aware registered read port into the execute stage. It adds an iterative radix-2 divider, signed or unsigned, that raises a stall request while busy and presents quotient and remainder for the execute stage to route into the LO and HI write paths.

---
 rtl/hilo_mdu_pkg.sv | 11 +
 rtl/hilo_mdu_div_iter.sv | 122 ++++++++++++
 rtl/hilo_mdu.sv | 104 ++++++++++
 tb/tb_hilo_mdu.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO special-register unit: stall-bus width,
// Stop/NoStop encodings and the divider state type.
package hilo_mdu_pkg;

   localparam int unsigned StallW = 6;
   localparam logic        Stop   = 1'b1;
   localparam logic        NoStop = 1'b0;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per
// cycle, with sign fix-up applied as the result is captured.
module div_iter
   import hilo_mdu_pkg::*;
#(
   parameter int unsigned DataW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [DataW-1:0] a_i,
   input  logic [DataW-1:0] b_i,
   input  logic             cancel_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DataW-1:0] quot_o,
   output logic [DataW-1:0] rem_o,
   output logic             stallreq_o
);

   localparam int unsigned CntW = $clog2(DataW + 1);

   div_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DataW-1:0]  rem_q, rem_d;
   logic [DataW-1:0]  quot_q, quot_d;
   logic [DataW-1:0]  dvsr_q, dvsr_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;
   logic [DataW-1:0]  quot_res_q, quot_res_d;
   logic [DataW-1:0]  rem_res_q, rem_res_d;

   logic              a_neg, b_neg, take;
   logic [DataW-1:0]  a_abs, b_abs, rem_step, quot_step;
   logic [DataW:0]    shifted, diff;

   assign a_neg = signed_i & a_i[DataW-1];
   assign b_neg = signed_i & b_i[DataW-1];
   assign a_abs = a_neg ? -a_i : a_i;
   assign b_abs = b_neg ? -b_i : b_i;

   // A zero divisor always subtracts, yielding all-ones quotient and |a| remainder.
   assign shifted   = {rem_q, quot_q[DataW-1]};
   assign diff      = shifted - {1'b0, dvsr_q};
   assign take      = ~diff[DataW];
   assign rem_step  = take ? diff[DataW-1:0] : shifted[DataW-1:0];
   assign quot_step = {quot_q[DataW-2:0], take};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      dvsr_d     = dvsr_q;
      negq_d     = negq_q;
      negr_d     = negr_q;
      quot_res_d = quot_res_q;
      rem_res_d  = rem_res_q;
      if (cancel_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_d = StBusy;
                  cnt_d   = CntW'(DataW);
                  rem_d   = '0;
                  quot_d  = a_abs;
                  dvsr_d  = b_abs;
                  // Divide-by-zero quotient stays all ones regardless of signs.
                  negq_d  = (a_neg ^ b_neg) & (b_i != '0);
                  negr_d  = a_neg;
               end
            end
            StBusy: begin
               rem_d  = rem_step;
               quot_d = quot_step;
               cnt_d  = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_d    = StDone;
                  quot_res_d = negq_q ? -quot_step : quot_step;
                  rem_res_d  = negr_q ? -rem_step : rem_step;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvsr_q     <= '0;
         negq_q     <= 1'b0;
         negr_q     <= 1'b0;
         quot_res_q <= '0;
         rem_res_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         dvsr_q     <= dvsr_d;
         negq_q     <= negq_d;
         negr_q     <= negr_d;
         quot_res_q <= quot_res_d;
         rem_res_q  <= rem_res_d;
      end
   end

   assign busy_o     = (state_q == StBusy);
   assign done_o     = (state_q == StDone);
   assign quot_o     = quot_res_q;
   assign rem_o      = rem_res_q;
   assign stallreq_o = ((state_q == StIdle) & start_i & ~cancel_i) | busy_o;

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO special-register unit: architectural HI/LO, priority forwarding network,
// stall-aware registered read port and the iterative divider.
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NFWD    = 6,
   parameter int unsigned STALL_W = StallW,
   parameter int unsigned SLOT    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [STALL_W-1:0]     stall,
   input  logic [NFWD-1:0]        fwd_hi_we,
   input  logic [NFWD-1:0]        fwd_lo_we,
   input  logic [NFWD*DATA_W-1:0] fwd_hi,
   input  logic [NFWD*DATA_W-1:0] fwd_lo,
   output logic [DATA_W-1:0]      hi_o,
   output logic [DATA_W-1:0]      lo_o,
   input  logic                   div_start,
   input  logic                   div_signed,
   input  logic [DATA_W-1:0]      div_a,
   input  logic [DATA_W-1:0]      div_b,
   input  logic                   div_cancel,
   output logic                   div_busy,
   output logic                   div_done,
   output logic [DATA_W-1:0]      div_quot,
   output logic [DATA_W-1:0]      div_rem,
   output logic                   stallreq_div
);

   logic [DATA_W-1:0] hi_src [NFWD];
   logic [DATA_W-1:0] lo_src [NFWD];
   logic [DATA_W-1:0] hi_fwd, lo_fwd;
   logic [DATA_W-1:0] hi_r_q, hi_r_d, lo_r_q, lo_r_d;
   logic [DATA_W-1:0] hi_o_q, hi_o_d, lo_o_q, lo_o_d;
   logic              unused_stall;

   assign unused_stall = ^stall;

   for (genvar k = 0; k < NFWD; k++) begin : g_fwd
      assign hi_src[k] = fwd_hi[k*DATA_W +: DATA_W];
      assign lo_src[k] = fwd_lo[k*DATA_W +: DATA_W];
   end

   // Walk oldest to youngest so the lowest-index writer wins.
   always_comb begin
      hi_fwd = hi_r_q;
      lo_fwd = lo_r_q;
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (fwd_hi_we[k]) hi_fwd = hi_src[k];
         if (fwd_lo_we[k]) lo_fwd = lo_src[k];
      end
   end

   always_comb begin
      hi_r_d = fwd_hi_we[NFWD-1] ? hi_src[NFWD-1] : hi_r_q;
      lo_r_d = fwd_lo_we[NFWD-1] ? lo_src[NFWD-1] : lo_r_q;
      hi_o_d = hi_o_q;
      lo_o_d = lo_o_q;
      if (stall[SLOT] == Stop && stall[SLOT+1] == NoStop) begin
         hi_o_d = '0;
         lo_o_d = '0;
      end else if (stall[SLOT] == NoStop) begin
         hi_o_d = hi_fwd;
         lo_o_d = lo_fwd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r_q <= '0;
         lo_r_q <= '0;
         hi_o_q <= '0;
         lo_o_q <= '0;
      end else begin
         hi_r_q <= hi_r_d;
         lo_r_q <= lo_r_d;
         hi_o_q <= hi_o_d;
         lo_o_q <= lo_o_d;
      end
   end

   assign hi_o = hi_o_q;
   assign lo_o = lo_o_q;

   div_iter #(
      .DataW (DATA_W)
   ) u_div_iter (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .signed_i   (div_signed),
      .a_i        (div_a),
      .b_i        (div_b),
      .cancel_i   (div_cancel),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem),
      .stallreq_o (stallreq_div)
   );

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomised bench for hilo_mdu against a behavioural model, with directed
// literal checks for forwarding, stall, divide results, latency and cancel.
module tb_hilo_mdu;

   localparam int DW = 32;
   localparam int NF = 6;
   localparam int SW = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [SW-1:0]     stall;
   logic [NF-1:0]     fwd_hi_we, fwd_lo_we;
   logic [NF*DW-1:0]  fwd_hi, fwd_lo;
   logic [DW-1:0]     hi_o, lo_o;
   logic              div_start, div_signed, div_cancel;
   logic [DW-1:0]     div_a, div_b;
   logic              div_busy, div_done, stallreq_div;
   logic [DW-1:0]     div_quot, div_rem;

   int n_cmp = 0;
   int n_fail = 0;

   hilo_mdu #(
      .DATA_W  (DW),
      .NFWD    (NF),
      .STALL_W (SW),
      .SLOT    (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .fwd_hi_we    (fwd_hi_we),
      .fwd_lo_we    (fwd_lo_we),
      .fwd_hi       (fwd_hi),
      .fwd_lo       (fwd_lo),
      .hi_o         (hi_o),
      .lo_o         (lo_o),
      .div_start    (div_start),
      .div_signed   (div_signed),
      .div_a        (div_a),
      .div_b        (div_b),
      .div_cancel   (div_cancel),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .div_quot     (div_quot),
      .div_rem      (div_rem),
      .stallreq_div (stallreq_div)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [DW-1:0] fwd_pick(input logic [NF-1:0] we,
                                              input logic [NF*DW-1:0] d,
                                              input logic [DW-1:0] arch);
      logic [DW-1:0] r;
      bit            found;
      r = arch;
      found = 0;
      for (int k = 0; k < NF; k++) begin
         if (we[k] && !found) begin
            r = d[k*DW +: DW];
            found = 1;
         end
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_quot(input logic [DW-1:0] a, b, input bit s);
      longint sa, sb, t;
      if (b == '0) return '1;
      if (!s) return a / b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t = sa / sb;
      return t[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] ref_rem(input logic [DW-1:0] a, b, input bit s);
      longint sa, sb, t;
      if (b == '0) return a;
      if (!s) return a % b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      t = sa % sb;
      return t[DW-1:0];
   endfunction

   logic [DW-1:0] m_hi_r, m_lo_r, m_hi_o, m_lo_o, m_q, m_r, p_q, p_r;
   bit            m_busy, m_done;
   int            m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hi_r <= '0; m_lo_r <= '0; m_hi_o <= '0; m_lo_o <= '0;
         m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0;
         m_busy <= 0; m_done <= 0; m_left <= 0;
      end else begin
         if (stall[3] && !stall[4]) begin
            m_hi_o <= '0;
            m_lo_o <= '0;
         end else if (!stall[3]) begin
            m_hi_o <= fwd_pick(fwd_hi_we, fwd_hi, m_hi_r);
            m_lo_o <= fwd_pick(fwd_lo_we, fwd_lo, m_lo_r);
         end
         if (fwd_hi_we[NF-1]) m_hi_r <= fwd_hi[(NF-1)*DW +: DW];
         if (fwd_lo_we[NF-1]) m_lo_r <= fwd_lo[(NF-1)*DW +: DW];
         if (div_cancel) begin
            m_busy <= 0;
            m_done <= 0;
         end else if (m_done) begin
            m_done <= 0;
         end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 0;
               m_done <= 1;
               m_q <= p_q;
               m_r <= p_r;
            end
         end else if (div_start) begin
            m_busy <= 1;
            m_left <= DW;
            p_q <= ref_quot(div_a, div_b, div_signed);
            p_r <= ref_rem(div_a, div_b, div_signed);
         end
      end
   end

   always @(negedge clk) begin
      check("hi_o", hi_o, m_hi_o);
      check("lo_o", lo_o, m_lo_o);
      check("div_busy", DW'(div_busy), DW'(m_busy));
      check("div_done", DW'(div_done), DW'(m_done));
      check("div_quot", div_quot, m_q);
      check("div_rem", div_rem, m_r);
      check("stallreq_div", DW'(stallreq_div),
            DW'(m_busy || (!m_done && div_start && !div_cancel)));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clr();
      stall = '0; fwd_hi_we = '0; fwd_lo_we = '0; fwd_hi = '0; fwd_lo = '0;
      div_start = 0; div_signed = 0; div_cancel = 0; div_a = '0; div_b = '0;
   endtask

   task automatic run_div(input logic [DW-1:0] a, b, input bit s,
                          input logic [DW-1:0] eq, er, input string nm);
      int done_at, n_st;
      step();
      div_a = a; div_b = b; div_signed = s; div_start = 1;
      #1;
      check({nm, "_stallreq_start"}, DW'(stallreq_div), 1);
      n_st = stallreq_div ? 1 : 0;
      step();
      div_start = 0;
      done_at = 0;
      for (int i = 1; i <= 40 && done_at == 0; i++) begin
         sample();
         if (div_done) done_at = i;
         else if (stallreq_div) n_st++;
      end
      check({nm, "_latency"}, DW'(done_at), 33);
      check({nm, "_stall_cycles"}, DW'(n_st), 33);
      check({nm, "_quot"}, div_quot, eq);
      check({nm, "_rem"}, div_rem, er);
   endtask

   initial begin
      int n_done;
      clr();
      repeat (3) step();
      rst_n = 1;
      step();

      // commit from writeback
      fwd_hi_we = 6'b100000; fwd_lo_we = 6'b100000;
      fwd_hi[5*DW +: DW] = 32'h1234; fwd_lo[5*DW +: DW] = 32'h5678;
      step();
      clr();
      sample();
      check("commit_hi", hi_o, 32'h1234);
      check("commit_lo", lo_o, 32'h5678);
      step();
      sample();
      check("commit_hold_hi", hi_o, 32'h1234);
      check("commit_hold_lo", lo_o, 32'h5678);

      // forwarding priority
      fwd_hi_we = 6'b100101;
      fwd_hi[0 +: DW] = 32'hA; fwd_hi[2*DW +: DW] = 32'hB; fwd_hi[5*DW +: DW] = 32'hC;
      step();
      fwd_hi_we = 6'b100000;
      sample();
      check("prio_hi_src0", hi_o, 32'hA);
      check("prio_lo_kept", lo_o, 32'h5678);
      step();
      clr();
      sample();
      check("prio_hi_src5", hi_o, 32'hC);

      // stall: hold, bubble, reload
      stall = 6'b011000;
      step();
      sample();
      check("stall_hold_hi", hi_o, 32'hC);
      stall = 6'b001000;
      step();
      sample();
      check("stall_bubble_hi", hi_o, 32'h0);
      check("stall_bubble_lo", lo_o, 32'h0);
      stall = 6'b000000;
      step();
      sample();
      check("stall_reload_hi", hi_o, 32'hC);
      check("stall_reload_lo", lo_o, 32'h5678);

      // asynchronous reset mid-cycle
      rst_n = 0;
      #1;
      check("async_rst_hi", hi_o, 32'h0);
      check("async_rst_lo", lo_o, 32'h0);
      step();
      rst_n = 1;
      step();
      sample();
      check("arch_rst_hi", hi_o, 32'h0);

      // divides
      run_div(32'd100, 32'd7, 0, 32'd14, 32'd2, "udiv_100_7");
      run_div(32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, "sdiv_m7_2");
      run_div(32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0, "sdiv_min_m1");
      run_div(32'hFFFFFFFB, 32'h0, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, "sdiv_by0");
      run_div(32'd123, 32'h0, 0, 32'hFFFFFFFF, 32'd123, "udiv_by0");

      // cancel in BUSY cycle 10
      step();
      div_a = 32'd1000; div_b = 32'd3; div_signed = 0; div_start = 1;
      step();
      div_start = 0;
      repeat (9) step();
      div_cancel = 1;
      step();
      div_cancel = 0;
      sample();
      check("cancel_busy", DW'(div_busy), 0);
      check("cancel_stallreq", DW'(stallreq_div), 0);
      n_done = 0;
      repeat (40) begin
         sample();
         if (div_done) n_done++;
      end
      check("cancel_no_done", DW'(n_done), 0);
      check("cancel_quot_kept", div_quot, 32'hFFFFFFFF);
      check("cancel_rem_kept", div_rem, 32'd123);

      // start with cancel in IDLE is rejected
      step();
      div_start = 1; div_cancel = 1; div_a = 32'd9; div_b = 32'd2;
      #1;
      check("start_cancel_stallreq", DW'(stallreq_div), 0);
      step();
      clr();
      sample();
      check("start_cancel_busy", DW'(div_busy), 0);

      // randomised traffic
      repeat (3000) begin
         int sel;
         step();
         fwd_hi_we = NF'($urandom & $urandom);
         fwd_lo_we = NF'($urandom & $urandom);
         for (int k = 0; k < NF; k++) begin
            fwd_hi[k*DW +: DW] = $urandom;
            fwd_lo[k*DW +: DW] = $urandom;
         end
         sel = $urandom_range(0, 3);
         stall = (sel == 0) ? 6'b000000 : (sel == 1) ? 6'b001000 :
                 (sel == 2) ? 6'b011000 : SW'($urandom);
         div_start  = ($urandom_range(0, 3) == 0);
         div_cancel = ($urandom_range(0, 49) == 0);
         div_signed = $urandom_range(0, 1) == 1;
         div_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         sel = $urandom_range(0, 7);
         div_b = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFFFFFF :
                 (sel == 2) ? DW'($urandom_range(1, 20)) : $urandom;
      end
      step();
      clr();
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
